// File: rtl/register_bus_reader.sv
// register_bus_reader: sweeps registers on a shared tri-state bus one at a time,
// capturing each word after a settle time and handing it downstream via valid/ready.
module register_bus_reader #(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 16,
    parameter int SettleCycles = 1,
    localparam int CW = $clog2(NrOfRegs + 1),
    localparam int IW = (NrOfRegs > 1) ? $clog2(NrOfRegs) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [CW-1:0]       count_i,
    input  logic                abort_i,
    output logic [NrOfRegs-1:0] cs_o,
    input  logic [NrOfBits-1:0] bus_i,
    output logic [NrOfBits-1:0] out_data_o,
    output logic [IW-1:0]       out_idx_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o,
    output logic                done_o
);
    localparam int SW = $clog2(SettleCycles + 1);
    localparam logic [NrOfRegs-1:0] ONE = NrOfRegs'(1);
    localparam logic [CW-1:0] MAXC = CW'(NrOfRegs);
    localparam logic [IW-1:0] LASTI = IW'(NrOfRegs - 1);
    localparam logic [SW-1:0] SEND = SW'(SettleCycles - 1);

    typedef enum logic [1:0] {IDLE, SEL, WAIT} state_t;

    state_t                state_q;
    logic [NrOfRegs-1:0]   cs_q;
    logic [NrOfBits-1:0]   data_q;
    logic [IW-1:0]         oidx_q, idx_q, last_q, idx_d;
    logic [SW-1:0]         settle_q;
    logic                  valid_q, busy_q, done_q;

    assign idx_d = idx_q + 1'b1;

    // cs only ever goes low from an all-ones state, so the WAIT cycle keeps selects break-before-make
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cs_q     <= '1;
            data_q   <= '0;
            oidx_q   <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            settle_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && abort_i) begin
                cs_q    <= '1;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (start_i && !abort_i) begin
                        idx_q    <= '0;
                        settle_q <= '0;
                        if (count_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            last_q  <= (count_i > MAXC) ? LASTI : IW'(count_i - 1'b1);
                            cs_q    <= ~ONE;
                            busy_q  <= 1'b1;
                            state_q <= SEL;
                        end
                    end
                    SEL: begin
                        if (settle_q == SEND) begin
                            data_q  <= bus_i;
                            oidx_q  <= idx_q;
                            valid_q <= 1'b1;
                            cs_q    <= '1;
                            state_q <= WAIT;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end
                    default: if (valid_q && out_ready_i) begin
                        valid_q <= 1'b0;
                        if (idx_q == last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q    <= idx_d;
                            settle_q <= '0;
                            cs_q     <= ~(ONE << idx_d);
                            state_q  <= SEL;
                        end
                    end
                endcase
            end
        end
    end

    assign cs_o        = cs_q;
    assign out_data_o  = data_q;
    assign out_idx_o   = oidx_q;
    assign out_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_register_bus_reader.sv
// tb_register_bus_reader: directed sweeps against two readers (settle 1 and settle 3)
// with a scoreboard of expected {index, word} pairs per reader.
module tb_register_bus_reader;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
    logic       start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
    logic [2:0] count_a = '0, count_b = '0;
    logic [3:0] cs_a, cs_b;
    logic [7:0] bus_a, bus_b, data_a, data_b;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [7:0] regs_a [4];
    logic [7:0] regs_b [4];
    logic [9:0] q_a [$];
    logic [9:0] q_b [$];
    int total = 0, bad = 0, cyc = 0, last_t = 0, contention = 0, done_cnt_a = 0, done_cnt_b = 0;
    int ts [4];
    int low, n;
    bit ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        bus_a = 'z;
        bus_b = 'z;
        for (int i = 0; i < 4; i++) begin
            if (!cs_a[i]) bus_a = regs_a[i];
            if (!cs_b[i]) bus_b = regs_b[i];
        end
    end

    always @(negedge clk) begin
        if ($countones(~cs_a) > 1 || $countones(~cs_b) > 1) contention++;
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    register_bus_reader #(.NrOfBits(8), .NrOfRegs(4), .SettleCycles(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .count_i(count_a), .abort_i(abort_a),
        .cs_o(cs_a), .bus_i(bus_a), .out_data_o(data_a), .out_idx_o(idx_a), .out_valid_o(valid_a),
        .out_ready_i(ready_a), .busy_o(busy_a), .done_o(done_a));

    register_bus_reader #(.NrOfBits(8), .NrOfRegs(4), .SettleCycles(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .count_i(count_b), .abort_i(abort_b),
        .cs_o(cs_b), .bus_i(bus_b), .out_data_o(data_b), .out_idx_o(idx_b), .out_valid_o(valid_b),
        .out_ready_i(ready_b), .busy_o(busy_b), .done_o(done_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input bit b, input string tag);
        int k = 0;
        while (!(b ? valid_b : valid_a) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_timeout"}, 32'(k < 50), 1);
    endtask

    task automatic take(input bit b, input string tag);
        int k = 0;
        logic [9:0] e;
        while (!(b ? (valid_b && ready_b) : (valid_a && ready_a)) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_timeout"}, 32'(k < 50), 1);
        chk({tag, "_sb"}, 32'((b ? q_b.size() : q_a.size()) > 0), 1);
        e = 10'h3ff;
        if (b && q_b.size() > 0) e = q_b.pop_front();
        if (!b && q_a.size() > 0) e = q_a.pop_front();
        chk({tag, "_data"}, b ? data_b : data_a, e[7:0]);
        chk({tag, "_idx"}, b ? idx_b : idx_a, e[9:8]);
        last_t = cyc;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            regs_a[i] = 8'hA0 + 8'(i);
            regs_b[i] = 8'h55;
        end
        repeat (2) @(negedge clk);
        chk("rst_cs", cs_a, 4'hf);
        chk("rst_valid", valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_idx", idx_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        count_b = 3'd1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("midsel_cs", cs_b, 4'he);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cs", cs_b, 4'hf);
        chk("async_busy", busy_b, 0);
        chk("async_valid", valid_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        ready_a = 1'b1;
        for (int i = 0; i < 4; i++) q_a.push_back({2'(i), 8'hA0 + 8'(i)});
        count_a = 3'd4; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("sweep_first_cs", cs_a, 4'he);
        for (int i = 0; i < 4; i++) begin
            take(0, "sweep");
            ts[i] = last_t;
        end
        chk("sweep_done", done_a, 1);
        for (int i = 1; i < 4; i++) chk("sweep_gap", 32'(ts[i] - ts[i-1]), 2);
        @(negedge clk);
        chk("sweep_done_pulse", done_a, 0);
        chk("sweep_idle", busy_a, 0);

        ready_a = 1'b0;
        q_a.push_back({2'd0, 8'hA0});
        q_a.push_back({2'd1, 8'hA1});
        count_a = 3'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_valid(0, "bp_valid");
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (data_a !== 8'hA0 || cs_a !== 4'hf || !valid_a) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 1);
        ready_a = 1'b1;
        take(0, "bp");
        take(0, "bp");
        chk("bp_done", done_a, 1);

        count_a = 3'd0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("cnt0_done", done_a, 1);
        chk("cnt0_cs", cs_a, 4'hf);
        chk("cnt0_busy", busy_a, 0);
        @(negedge clk);
        chk("cnt0_pulse", done_a, 0);

        for (int i = 0; i < 4; i++) q_a.push_back({2'(i), 8'hA0 + 8'(i)});
        count_a = 3'd7; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        take(0, "cnt7");
        start_a = 1'b1; count_a = 3'd1;
        @(negedge clk);
        start_a = 1'b0; count_a = 3'd0;
        for (int i = 0; i < 3; i++) take(0, "cnt7");
        chk("cnt7_done", done_a, 1);
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (valid_a || busy_a) ok = 1'b0;
        end
        chk("cnt7_no_extra", 32'(ok), 1);
        chk("cnt7_sb_empty", 32'(q_a.size()), 0);

        ready_a = 1'b0;
        count_a = 3'd4; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_valid(0, "abort_valid");
        chk("abort_pre_data", data_a, 8'hA0);
        ready_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0; ready_a = 1'b0;
        chk("abort_valid", valid_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_cs", cs_a, 4'hf);
        chk("abort_nodone", done_a, 0);
        chk("abort_keep_data", data_a, 8'hA0);
        chk("abort_keep_idx", idx_a, 0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", 32'({valid_a, busy_a}), 0);
        q_a.push_back({2'd0, 8'hA0});
        q_a.push_back({2'd1, 8'hA1});
        ready_a = 1'b1;
        count_a = 3'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        take(0, "restart");
        take(0, "restart");
        chk("restart_done", done_a, 1);

        ready_b = 1'b1;
        regs_b[0] = 8'h11;
        q_b.push_back({2'd0, 8'h22});
        count_b = 3'd1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        low = 0; n = 0;
        while (!valid_b && n < 20) begin
            if (cs_b == 4'he) low++;
            if (low == 2) regs_b[0] = 8'h22;
            @(negedge clk);
            n++;
        end
        chk("settle_low_cycles", 32'(low), 3);
        chk("settle_cs_after", cs_b, 4'hf);
        take(1, "settle");
        chk("settle_done", done_b, 1);

        repeat (3) @(negedge clk);
        chk("no_contention", 32'(contention), 0);
        chk("done_count_a", 32'(done_cnt_a), 5);
        chk("done_count_b", 32'(done_cnt_b), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
